// File: rtl/uart_tx_arbiter_if.sv
// Request side (NUM_REQ packet sources) and TX side (packet handler) of uart_tx_arbiter.
// The arbiter connects through the slave modport; sources and handler use master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]    req_meta_valid;
  logic [NUM_REQ-1:0]    req_meta_ready;
  logic [NUM_REQ*8-1:0]  req_cmd;
  logic [NUM_REQ*16-1:0] req_length;
  logic [NUM_REQ*8-1:0]  req_payload_data;
  logic [NUM_REQ-1:0]    req_payload_valid;
  logic [NUM_REQ-1:0]    req_payload_last;
  logic [NUM_REQ-1:0]    req_payload_ready;

  logic                  tx_meta_valid;
  logic                  tx_meta_ready;
  logic [7:0]            tx_cmd;
  logic [15:0]           tx_length;
  logic [7:0]            tx_payload_data;
  logic                  tx_payload_valid;
  logic                  tx_payload_last;
  logic                  tx_payload_ready;

  logic [IDW-1:0]        grant_id;
  logic                  busy;
  logic                  proto_error;
  logic [IDW-1:0]        err_req_id;

  modport slave (
    input  req_meta_valid, req_cmd, req_length, req_payload_data,
           req_payload_valid, req_payload_last, tx_meta_ready, tx_payload_ready,
    output req_meta_ready, req_payload_ready, tx_meta_valid, tx_cmd, tx_length,
           tx_payload_data, tx_payload_valid, tx_payload_last,
           grant_id, busy, proto_error, err_req_id
  );

  modport master (
    output req_meta_valid, req_cmd, req_length, req_payload_data,
           req_payload_valid, req_payload_last, tx_meta_ready, tx_payload_ready,
    input  req_meta_ready, req_payload_ready, tx_meta_valid, tx_cmd, tx_length,
           tx_payload_data, tx_payload_valid, tx_payload_last,
           grant_id, busy, proto_error, err_req_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter: grants one source per packet, forwards meta and payload
// to the packet handler and forces the payload to exactly the declared length.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_META    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PAD     = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] err_id_q, err_id_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           meta_valid_q, meta_valid_d;
  logic           busy_q, busy_d;
  logic           perr_q, perr_d;

  logic           found;
  logic           hit;
  logic [IDW-1:0] win;
  int             idx;
  logic           g_valid;
  logic           g_last;
  logic [7:0]     g_data;
  logic           last_beat;

  // First requesting source at or after rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    found = 1'b0;
    hit   = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k >= NUM_REQ) ? int'(rr_ptr_q) + k - NUM_REQ : int'(rr_ptr_q) + k;
      hit   = bus.req_meta_valid[idx] && !found;
      win   = hit ? IDW'(idx) : win;
      found = found || bus.req_meta_valid[idx];
    end
  end

  assign g_valid   = bus.req_payload_valid[gid_q];
  assign g_last    = bus.req_payload_last[gid_q];
  assign g_data    = bus.req_payload_data[{gid_q, 3'b000} +: 8];
  assign last_beat = (cnt_q == len_q - 16'd1);

  // Next state, payload pass-through and per-source ready steering
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gid_d    = gid_q;
    err_id_d = err_id_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    perr_d   = 1'b0;

    bus.req_meta_ready    = '0;
    bus.req_payload_ready = '0;
    bus.tx_payload_valid  = 1'b0;
    bus.tx_payload_data   = 8'h00;
    bus.tx_payload_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // No grant while reset is held so every ready reads 0 during reset
        if (found && !rst) begin
          bus.req_meta_ready[win] = 1'b1;
          cmd_d    = bus.req_cmd[{win, 3'b000} +: 8];
          len_d    = bus.req_length[{win, 4'b0000} +: 16];
          gid_d    = win;
          cnt_d    = 16'd0;
          rr_ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + IDW'(1);
          state_d  = S_META;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_META: begin
        if (meta_valid_q && bus.tx_meta_ready) begin
          state_d = (len_q != 16'd0) ? S_PAYLOAD : S_IDLE;
        end else begin
          state_d = S_META;
        end
      end
      S_PAYLOAD: begin
        bus.tx_payload_valid         = g_valid;
        bus.tx_payload_data          = g_data;
        bus.tx_payload_last          = last_beat;
        bus.req_payload_ready[gid_q] = bus.tx_payload_ready;
        if (g_valid && bus.tx_payload_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (last_beat && g_last) begin
            state_d = S_IDLE;
          end else if (last_beat || g_last) begin
            // Long packet: discard the excess. Short packet: zero-fill to length.
            perr_d   = 1'b1;
            err_id_d = gid_q;
            state_d  = last_beat ? S_DRAIN : S_PAD;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          state_d = S_PAYLOAD;
        end
      end
      S_PAD: begin
        bus.tx_payload_valid = 1'b1;
        bus.tx_payload_data  = 8'h00;
        bus.tx_payload_last  = last_beat;
        if (bus.tx_payload_ready) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = last_beat ? S_IDLE : S_PAD;
        end else begin
          state_d = S_PAD;
        end
      end
      S_DRAIN: begin
        bus.req_payload_ready[gid_q] = 1'b1;
        if (g_valid && g_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    meta_valid_d = (state_d == S_META);
    busy_d       = (state_d != S_IDLE);
  end

  // State, captured meta, counters and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gid_q        <= '0;
      err_id_q     <= '0;
      cmd_q        <= 8'h00;
      len_q        <= 16'h0000;
      cnt_q        <= 16'h0000;
      meta_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gid_q        <= gid_d;
      err_id_q     <= err_id_d;
      cmd_q        <= cmd_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      meta_valid_q <= meta_valid_d;
      busy_q       <= busy_d;
      perr_q       <= perr_d;
    end
  end

  assign bus.tx_meta_valid = meta_valid_q;
  assign bus.tx_cmd        = cmd_q;
  assign bus.tx_length     = len_q;
  assign bus.grant_id      = gid_q;
  assign bus.busy          = busy_q;
  assign bus.proto_error   = perr_q;
  assign bus.err_req_id    = err_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scripted and random packets from behavioural
// sources, compared against a per-packet round-robin / length-enforcement model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]   src;
    logic [7:0]   cmd;
    logic [15:0]  len;
    logic [4:0]   nb;
    logic [127:0] b;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  uart_tx_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_fail = 0;
  pkt_t pkts[$];
  logic [25:0] obs_meta[$], exp_meta[$];
  logic [8:0]  obs_bytes[$], exp_bytes[$];
  logic [1:0]  obs_err[$], exp_err[$];
  int phase[N], cur[N], bidx[N], nxt[N];
  int model_ptr = 0;
  bit gap_en = 1'b0;

  function automatic int find_next(input int i, input int from);
    for (int k = from; k < pkts.size(); k++) begin
      if (int'(pkts[k].src) == i) return k;
    end
    return -1;
  endfunction

  task automatic add_pkt(input int src, input logic [7:0] cmd, input int len, input int nb,
                         input logic [127:0] b);
    pkt_t p;
    p.src = 2'(src); p.cmd = cmd; p.len = 16'(len); p.nb = 5'(nb); p.b = b;
    pkts.push_back(p);
  endtask

  function automatic logic [127:0] rand_bytes();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_run();
    pkts.delete(); obs_meta.delete(); obs_bytes.delete(); obs_err.delete();
    for (int i = 0; i < N; i++) begin
      phase[i] = 0; cur[i] = 0; bidx[i] = 0; nxt[i] = 0;
    end
  endtask

  task automatic drive_idle();
    bus.req_meta_valid = '0; bus.req_cmd = '0; bus.req_length = '0;
    bus.req_payload_data = '0; bus.req_payload_valid = '0; bus.req_payload_last = '0;
    bus.tx_meta_ready = 1'b0; bus.tx_payload_ready = 1'b0;
  endtask

  // Model: each IDLE grants the first source with a pending packet from the rr pointer;
  // the outgoing payload is always exactly len bytes (truncated or zero-filled).
  task automatic build_expected();
    int head[N];
    int found;
    int ptr;
    pkt_t p;
    exp_meta.delete(); exp_bytes.delete(); exp_err.delete();
    ptr = model_ptr;
    for (int i = 0; i < N; i++) head[i] = find_next(i, 0);
    for (int guard = 0; guard < 1000; guard++) begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        if (found < 0 && head[(ptr + k) % N] >= 0) found = (ptr + k) % N;
      end
      if (found < 0) break;
      p = pkts[head[found]];
      exp_meta.push_back({2'(found), p.cmd, p.len});
      for (int j = 0; j < int'(p.len); j++) begin
        exp_bytes.push_back({(j == int'(p.len) - 1), (j < int'(p.nb)) ? p.b[j*8 +: 8] : 8'h00});
      end
      if (p.len != 16'd0 && int'(p.nb) != int'(p.len)) exp_err.push_back(2'(found));
      ptr = (found + 1) % N;
      head[found] = find_next(found, head[found] + 1);
    end
    model_ptr = ptr;
  endtask

  task automatic run_traffic(input int mode, input int max_cyc, input int stop_bytes);
    bit prev_mv, prev_hs, meta_hs, all_done;
    logic [N-1:0] mask;
    pkt_t p;
    int k;
    prev_mv = 1'b0; prev_hs = 1'b0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (phase[i] == 0) begin
          k = find_next(i, nxt[i]);
          if (k >= 0) begin cur[i] = k; phase[i] = 1; end
        end
        p = (phase[i] != 0) ? pkts[cur[i]] : '0;
        bus.req_meta_valid[i]          = (phase[i] == 1);
        bus.req_cmd[i*8 +: 8]          = p.cmd;
        bus.req_length[i*16 +: 16]     = p.len;
        bus.req_payload_valid[i]       = (phase[i] == 2) && (!gap_en || $urandom_range(0, 3) != 0);
        bus.req_payload_data[i*8 +: 8] = (phase[i] == 2) ? p.b[bidx[i]*8 +: 8] : 8'h00;
        bus.req_payload_last[i]        = (phase[i] == 2) && (bidx[i] == int'(p.nb) - 1);
      end
      case (mode)
        1: begin bus.tx_meta_ready = 1'b1; bus.tx_payload_ready = ((cyc % 2) == 0); end
        2: begin
          bus.tx_meta_ready    = ($urandom_range(0, 3) != 0);
          bus.tx_payload_ready = ($urandom_range(0, 3) != 0);
        end
        default: begin bus.tx_meta_ready = 1'b1; bus.tx_payload_ready = 1'b1; end
      endcase
      #4;
      meta_hs = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (bus.req_meta_valid[i] && bus.req_meta_ready[i]) begin
          meta_hs = 1'b1;
          if (pkts[cur[i]].len == 16'd0) begin phase[i] = 0; nxt[i] = cur[i] + 1; end
          else begin phase[i] = 2; bidx[i] = 0; end
        end else if (bus.req_payload_valid[i] && bus.req_payload_ready[i]) begin
          bidx[i]++;
          if (bidx[i] == int'(pkts[cur[i]].nb)) begin phase[i] = 0; nxt[i] = cur[i] + 1; end
        end
      end
      if (bus.tx_meta_valid && bus.tx_meta_ready)
        obs_meta.push_back({bus.grant_id, bus.tx_cmd, bus.tx_length});
      if (bus.tx_payload_valid && bus.tx_payload_ready)
        obs_bytes.push_back({bus.tx_payload_last, bus.tx_payload_data});
      if (bus.proto_error) obs_err.push_back(bus.err_req_id);
      mask = (bus.busy && !bus.tx_meta_valid) ? (4'b0001 << bus.grant_id) : 4'b0000;
      n_cmp++;
      if ((bus.req_payload_ready & ~mask) !== 4'b0000) begin
        n_fail++;
        $display("FAIL payload_ready_owner: got %b allowed %b", bus.req_payload_ready, mask);
      end
      if (bus.tx_meta_valid && !prev_mv) begin
        n_cmp++;
        if (prev_hs !== 1'b1) begin
          n_fail++;
          $display("FAIL meta_latency: source meta handshake one cycle earlier got %b want 1", prev_hs);
        end
      end
      prev_mv = bus.tx_meta_valid;
      prev_hs = meta_hs;
      if (stop_bytes > 0 && obs_bytes.size() >= stop_bytes) return;
      all_done = !bus.busy && !bus.tx_meta_valid && !meta_hs;
      for (int i = 0; i < N; i++) begin
        if (phase[i] != 0 || find_next(i, nxt[i]) >= 0) all_done = 1'b0;
      end
      if (all_done) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL traffic_timeout: got still busy after %0d cycles want idle", max_cyc);
  endtask

  task automatic check_results(input string name);
    build_expected();
    n_cmp++;
    if (obs_meta.size() !== exp_meta.size()) begin
      n_fail++; $display("FAIL %s meta_count: got %0d want %0d", name, obs_meta.size(), exp_meta.size());
    end
    for (int i = 0; i < exp_meta.size() && i < obs_meta.size(); i++) begin
      n_cmp++;
      if (obs_meta[i] !== exp_meta[i]) begin
        n_fail++; $display("FAIL %s meta[%0d] {id,cmd,len}: got %h want %h", name, i, obs_meta[i], exp_meta[i]);
      end
    end
    n_cmp++;
    if (obs_bytes.size() !== exp_bytes.size()) begin
      n_fail++; $display("FAIL %s byte_count: got %0d want %0d", name, obs_bytes.size(), exp_bytes.size());
    end
    for (int i = 0; i < exp_bytes.size() && i < obs_bytes.size(); i++) begin
      n_cmp++;
      if (obs_bytes[i] !== exp_bytes[i]) begin
        n_fail++; $display("FAIL %s byte[%0d] {last,data}: got %h want %h", name, i, obs_bytes[i], exp_bytes[i]);
      end
    end
    n_cmp++;
    if (obs_err.size() !== exp_err.size()) begin
      n_fail++; $display("FAIL %s error_count: got %0d want %0d", name, obs_err.size(), exp_err.size());
    end
    for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
      n_cmp++;
      if (obs_err[i] !== exp_err[i]) begin
        n_fail++; $display("FAIL %s err_id[%0d]: got %0d want %0d", name, i, obs_err[i], exp_err[i]);
      end
    end
    clear_run();
  endtask

  task automatic apply_reset(input string name);
    logic [2:0]  hs;
    logic [31:0] dat;
    logic [7:0]  rdy;
    logic [5:0]  st;
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1;
    hs  = {bus.tx_meta_valid, bus.tx_payload_valid, bus.tx_payload_last};
    dat = {bus.tx_cmd, bus.tx_length, bus.tx_payload_data};
    rdy = {bus.req_meta_ready, bus.req_payload_ready};
    st  = {bus.grant_id, bus.busy, bus.proto_error, bus.err_req_id};
    n_cmp++; if (hs !== 3'b000) begin n_fail++; $display("FAIL %s tx_valids: got %b want 000", name, hs); end
    n_cmp++; if (dat !== 32'h0) begin n_fail++; $display("FAIL %s tx_data: got %h want 0", name, dat); end
    n_cmp++; if (rdy !== 8'h00) begin n_fail++; $display("FAIL %s req_readys: got %b want 0", name, rdy); end
    n_cmp++; if (st !== 6'd0) begin n_fail++; $display("FAIL %s status: got %b want 0", name, st); end
    @(negedge clk);
    rst = 1'b0;
    clear_run();
    model_ptr = 0;
  endtask

  task automatic test_reset();
    apply_reset("reset");
  endtask

  task automatic test_basic();
    add_pkt(0, 8'hB1, 4, 4, 128'h44332211);
    run_traffic(0, 200, 0);
    check_results("basic");
  endtask

  task automatic test_round_robin();
    apply_reset("rr_reset");
    for (int i = 0; i < N; i++) add_pkt(i, 8'(8'h10 + i), 1, 1, rand_bytes());
    run_traffic(0, 300, 0);
    check_results("rr_all");
    add_pkt(2, 8'h22, 1, 1, rand_bytes());
    add_pkt(0, 8'h20, 1, 1, rand_bytes());
    run_traffic(0, 300, 0);
    check_results("rr_0_2");
  endtask

  task automatic test_zero_len();
    add_pkt(1, 8'hA0, 0, 0, 128'h0);
    run_traffic(0, 100, 0);
    check_results("zero_len");
  endtask

  task automatic test_pad();
    add_pkt(2, 8'hC2, 4, 2, 128'hA55A);
    run_traffic(0, 100, 0);
    check_results("pad");
  endtask

  task automatic test_drain();
    add_pkt(3, 8'hD3, 2, 3, 128'h030201);
    run_traffic(0, 100, 0);
    check_results("drain");
  endtask

  task automatic test_back_to_back_toggle();
    add_pkt(1, 8'h5C, 4, 4, rand_bytes());
    add_pkt(1, 8'h5D, 4, 4, rand_bytes());
    run_traffic(1, 300, 0);
    check_results("toggle_ready");
  endtask

  task automatic test_reset_mid();
    add_pkt(2, 8'hE2, 8, 8, rand_bytes());
    run_traffic(0, 100, 3);
    apply_reset("reset_mid");
    add_pkt(3, 8'hF3, 1, 1, rand_bytes());
    add_pkt(1, 8'hF1, 1, 1, rand_bytes());
    run_traffic(0, 200, 0);
    check_results("after_reset_mid");
  endtask

  task automatic test_random();
    int len, nb, sel;
    gap_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < int'($urandom_range(3, 8)); j++) begin
        len = $urandom_range(0, 8);
        sel = $urandom_range(0, 9);
        if (len == 0) nb = 0;
        else if (sel < 2 && len > 1) nb = $urandom_range(1, len - 1);
        else if (sel < 4) nb = len + $urandom_range(1, 3);
        else nb = len;
        add_pkt($urandom_range(0, N - 1), 8'($urandom), len, nb, rand_bytes());
      end
      run_traffic(2, 3000, 0);
      check_results("random");
    end
    gap_en = 1'b0;
  endtask

  initial begin
    drive_idle();
    clear_run();
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_len();
    test_pad();
    test_drain();
    test_back_to_back_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin packet arbiter that shares the single TX packet port of `uart_packet_handler` among `NUM_REQ` independent packet sources, such as command responses, status reports and matrix result streams. Each source presents a packet as a meta handshake (cmd, length) followed by a payload byte stream. The arbiter grants one source per packet, forwards its meta and payload to the handler, and enforces the declared length so the outgoing frame is always well-formed. It sits between the calculator's result/response generators and the packet handler's `tx_meta_*` / `tx_payload_*` ports.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `IDW`, default `$clog2(NUM_REQ)`: width of the requester index.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_meta_valid`  in  NUM_REQ  per-source packet request.
- `req_meta_ready`  out  NUM_REQ  per-source meta accept.
- `req_cmd`  in  NUM_REQ*8  per-source command byte; source i occupies bits [8i+7:8i].
- `req_length`  in  NUM_REQ*16  per-source payload length; source i occupies bits [16i+15:16i].
- `req_payload_data`  in  NUM_REQ*8  per-source payload byte.
- `req_payload_valid`  in  NUM_REQ  per-source payload valid.
- `req_payload_last`  in  NUM_REQ  per-source last-byte marker.
- `req_payload_ready`  out  NUM_REQ  per-source payload accept.
- `tx_meta_valid`  out  1  meta request to the packet handler.
- `tx_meta_ready`  in  1  meta accept from the packet handler.
- `tx_cmd`  out  8  registered command byte.
- `tx_length`  out  16  registered payload length.
- `tx_payload_data`  out  8  payload byte.
- `tx_payload_valid`  out  1  payload valid.
- `tx_payload_last`  out  1  last payload byte of the packet.
- `tx_payload_ready`  in  1  payload accept from the packet handler.
- `grant_id`  out  IDW  index of the currently or most recently granted source.
- `busy`  out  1  high in every state except IDLE.
- `proto_error`  out  1  one-cycle pulse on a last/length mismatch.
- `err_req_id`  out  IDW  source that caused the most recent error.

## Operation
- The FSM has five states: IDLE, META, PAYLOAD, PAD and DRAIN.
- IDLE:
  - Select the first asserted `req_meta_valid`, searching from `rr_ptr` upward with wrap-around.
  - In the same cycle, drive `req_meta_ready[w]=1` for the winner w only.
  - Capture cmd, length and w into registers, set the beat counter to 0, set `rr_ptr` to (w+1) mod NUM_REQ, and go to META.
- META:
  - Hold `tx_meta_valid=1` with the registered `tx_cmd` and `tx_length` until `tx_meta_ready`.
  - On the handshake, go to PAYLOAD if length≠0, otherwise go to IDLE.
- PAYLOAD (pass-through, combinational, granted source g only):
  - `tx_payload_valid = req_payload_valid[g]`, `tx_payload_data = req_payload_data[g]`, `req_payload_ready[g] = tx_payload_ready`.
  - `tx_payload_last = (cnt == length-1)`.
  - On each handshake, cnt increments by 1 (16-bit).
- Final beat (cnt==length-1) handshake:
  - If `req_payload_last[g]` is high, go to IDLE.
  - If it is low, pulse `proto_error` and go to DRAIN.
- Early last (handshake with `req_payload_last[g]` high and cnt<length-1):
  - Pulse `proto_error` and go to PAD.
- PAD:
  - Drive `tx_payload_valid=1` and `tx_payload_data=8'h00`, with `tx_payload_last` at cnt==length-1.
  - Keep `req_payload_ready` low.
  - Go to IDLE after the final pad beat handshake.
- DRAIN:
  - Drive `req_payload_ready[g]=1` and `tx_payload_valid=0`, discarding bytes.
  - Go to IDLE on the handshake carrying `req_payload_last[g]`.
- Non-granted sources always see ready=0. The granted source sees `req_payload_ready` low in IDLE and META.
- `req_payload_last` is ignored for zero-length packets; such a source must not present payload.

## Timing
- Reset values: `tx_meta_valid`, `tx_payload_valid` and `tx_payload_last` are 0; `tx_cmd`, `tx_length` and `tx_payload_data` are 0; all `req_*_ready` are 0; `grant_id`, `busy`, `proto_error` and `err_req_id` are 0; state is IDLE; `rr_ptr` is 0; cnt is 0.
- Reset mid-packet abandons the packet with no padding. The handler is reset together with the arbiter.
- Meta latency: `req_meta_valid` high in IDLE at cycle N gives `req_meta_ready` at N and `tx_meta_valid` at N+1.
- Payload adds zero latency; it is a combinational pass-through.
- A minimum of one IDLE cycle separates packets.
- `proto_error` and `err_req_id` are registered and update in the cycle after the offending handshake.
- Sources must hold meta stable while `req_meta_valid` is high. A request withdrawn in IDLE is not granted.

## Test plan
- Source 0 sends cmd B1, len 4, payload 11 22 33 44. Required: `req_meta_ready[0]` in the request cycle; next cycle `tx_meta_valid` with B1/0004; bytes 11..44 with `tx_payload_last` only on 44; back to IDLE with `busy` low.
- All four sources request simultaneously, len 1 each. Required: grants in order 0,1,2,3. Then sources 0 and 2 request again; required: grant 0, then 2.
- Source 1 sends cmd A0, len 0. Required: one meta handshake, no payload beat, `req_payload_ready[1]` stays 0, return to IDLE.
- Source 2 sends len 4 with bytes 5A A5, last on A5. Required: `proto_error` pulses with `err_req_id`=2; tx carries 5A A5 00 00 with last on the fourth byte.
- Source 3 sends len 2 with bytes 01 02 03, last on 03. Required: tx carries 01 02 with last on 02; 03 is drained; `proto_error` pulses with id 3.
- `tx_payload_ready` toggles every cycle during a len 4 packet. Required: no byte lost or duplicated. Then assert `rst` mid-payload; required: all outputs 0 the next cycle and the next grant searches from source 0.
